// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear/lap control with 10 ms prescaler and BCD mm:ss.cc counter
module stopwatch_ctrl #(
    parameter int TICK_CNT = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_ss,
    input  logic       key_clr,
    input  logic       key_lap,
    output logic       running,
    output logic       lap_hold,
    output logic       wrap,
    output logic [3:0] d_m1,
    output logic [3:0] d_m0,
    output logic [3:0] d_s1,
    output logic [3:0] d_s0,
    output logic [3:0] d_c1,
    output logic [3:0] d_c0
);
    localparam int PW = $clog2(TICK_CNT);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2;
    // digit limits, packed {m1, m0, s1, s0, c1, c0}
    localparam logic [23:0] LIMS = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    logic [1:0]    state;
    logic [PW-1:0] pre;
    logic [23:0]   live, lap, disp, live_inc, live_nxt;
    logic          tick, cy;

    assign tick     = state == RUN && pre == PW'(TICK_CNT - 1);
    assign live_nxt = tick ? live_inc : live;
    assign running  = state == RUN;
    assign {d_m1, d_m0, d_s1, d_s0, d_c1, d_c0} = disp;

    always_comb begin
        cy = 1'b1;
        live_inc = live;
        for (int i = 0; i < 6; i++) begin
            live_inc[i*4 +: 4] = cy ? (live[i*4 +: 4] == LIMS[i*4 +: 4] ? 4'd0 : live[i*4 +: 4] + 4'd1) : live[i*4 +: 4];
            cy = cy && live[i*4 +: 4] == LIMS[i*4 +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pre      <= '0;
            live     <= '0;
            lap      <= '0;
            disp     <= '0;
            lap_hold <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            wrap <= tick && cy;
            disp <= lap_hold ? lap : live;
            live <= live_nxt;
            if (state == RUN)
                pre <= tick ? '0 : pre + PW'(1);
            case (state)
                IDLE: if (key_ss) state <= RUN;
                RUN: begin
                    if (key_ss) begin
                        state    <= PAUSE;
                        lap_hold <= 1'b0;
                    end else if (key_lap) begin
                        lap_hold <= !lap_hold;
                        // capture includes any increment made at this same edge
                        if (!lap_hold) lap <= live_nxt;
                    end
                end
                PAUSE: begin
                    if (key_clr) begin
                        state <= IDLE;
                        pre   <= '0;
                        live  <= '0;
                        lap   <= '0;
                    end else if (key_ss) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
